// File: rtl/gfx_pkg.sv
// Shared playfield graphics types: tile word layout, pixel geometry,
// fetch FSM states and a nibble-select helper.
package gfx_pkg;

  localparam int PIX_PER_TILE = 8;
  localparam int PIX_W        = 4;
  localparam int ROW_W        = PIX_PER_TILE * PIX_W;

  typedef struct packed {
    logic        hflip;
    logic [2:0]  pal;
    logic [11:0] code;
  } tile_word_t;

  // One fetched tile row together with the attributes of its tile.
  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic [2:0]       pal;
    logic             hflip;
  } tile_row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } fetch_state_t;

  // Nibble 0 is the leftmost pixel and sits in the most significant bits.
  function automatic logic [PIX_W-1:0] row_pixel(input logic [ROW_W-1:0] data,
                                                 input logic [2:0]       nib);
    logic [4:0] lsb;
    lsb = {3'd7 - nib, 2'b00};
    return data[lsb +: PIX_W];
  endfunction

endpackage

// File: rtl/pf_pixel_window.sv
// Two-tile pixel window (prev/cur) with optional horizontal flip and fine
// scroll selection. Flip is honoured only when PF_HFLIP_EN is defined.
module pf_pixel_window
  import gfx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             line_start,
  input  logic             reload,
  input  tile_row_t        load_row,
  input  logic [2:0]       hscroll,
  input  logic [2:0]       pix_cnt,
  output logic [PIX_W-1:0] pf_pix,
  output logic [2:0]       pf_pal,
  output logic             pf_hflip
);

  tile_row_t  prev_r;
  tile_row_t  cur_r;
  tile_row_t  sel_s;
  logic [2:0] hs_q_r;
  logic [2:0] nib_s;
  logic [3:0] idx_s;

  // Pick the window pixel 8 + pix_cnt - hs_q; index bit 3 selects cur over prev.
  always_comb begin
    idx_s = 4'd8 + {1'b0, pix_cnt} - {1'b0, hs_q_r};
    if (idx_s[3]) begin
      sel_s = cur_r;
    end else begin
      sel_s = prev_r;
    end
`ifdef PF_HFLIP_EN
    if (sel_s.hflip) begin
      nib_s = ~idx_s[2:0];
    end else begin
      nib_s = idx_s[2:0];
    end
`else
    nib_s = idx_s[2:0];
`endif
  end

  // Window shift on reload, clear on line start, output register on pix_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r   <= '0;
      cur_r    <= '0;
      hs_q_r   <= 3'd0;
      pf_pix   <= '0;
      pf_pal   <= 3'd0;
      pf_hflip <= 1'b0;
    end else begin
      if (line_start) begin
        prev_r <= '0;
        cur_r  <= '0;
      end else if (reload) begin
        prev_r <= cur_r;
        cur_r  <= load_row;
        hs_q_r <= hscroll;
      end
      if (pix_en && !line_start) begin
        pf_pix   <= row_pixel(sel_s.data, nib_s);
        pf_pal   <= sel_s.pal;
        pf_hflip <= sel_s.hflip;
      end
    end
  end

endmodule

// File: rtl/playfield_shifter.sv
// Playfield tile shifter: tile fetch FSM, one-entry row buffer and pixel
// counter feeding the pixel window. Define PF_HFLIP_EN to honour VRD[15].
module playfield_shifter
  import gfx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        line_start,
  input  logic        tile_ld,
  input  logic [15:0] VRD,
  input  logic        PP18,
  input  logic [8:0]  PP,
  input  logic [2:0]  hscroll,
  output logic        gfx_req,
  output logic [15:0] gfx_addr,
  input  logic        gfx_ack,
  input  logic [31:0] gfx_data,
  output logic [3:0]  pf_pix,
  output logic [2:0]  pf_pal,
  output logic        pf_hflip,
  output logic        underrun_err,
  output logic        overrun_err
);

  fetch_state_t state_r, state_nxt_s;
  tile_word_t   tile_s;
  tile_row_t    buf_r, load_row_s, ack_row_s;
  logic [2:0]   pal_r;
  logic         hflip_r;
  logic [2:0]   pix_cnt_r;
  logic         reload_s, ack_s, drain_s, bypass_s, accept_s;
  logic         unused_s;

  assign tile_s    = tile_word_t'(VRD);
  assign unused_s  = ^{tile_s.hflip, PP[8:3]};
  assign ack_s     = (state_r == ST_FETCH) && gfx_ack;
  assign reload_s  = pix_en && !line_start && (pix_cnt_r == 3'd7);
  assign drain_s   = reload_s && (state_r == ST_READY);
  assign bypass_s  = reload_s && ack_s;
  assign accept_s  = tile_ld && ((state_r == ST_IDLE) || drain_s);
  assign ack_row_s = '{data: gfx_data, pal: pal_r, hflip: hflip_r};

  // Next fetch state and the row handed to the window at a reload edge.
  always_comb begin
    state_nxt_s = state_r;
    if (drain_s) begin
      load_row_s = buf_r;
    end else if (bypass_s) begin
      load_row_s = ack_row_s;
    end else begin
      load_row_s = '0;
    end
    case (state_r)
      ST_IDLE: begin
        if (tile_ld) state_nxt_s = ST_FETCH;
        else         state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (ack_s) state_nxt_s = bypass_s ? ST_IDLE : ST_READY;
        else       state_nxt_s = ST_FETCH;
      end
      ST_READY: begin
        if (drain_s) state_nxt_s = tile_ld ? ST_FETCH : ST_IDLE;
        else         state_nxt_s = ST_READY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request/address, tile attributes, row buffer, pixel counter, sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      gfx_req      <= 1'b0;
      gfx_addr     <= 16'd0;
      pal_r        <= 3'd0;
      hflip_r      <= 1'b0;
      buf_r        <= '0;
      pix_cnt_r    <= 3'd0;
      underrun_err <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      gfx_req <= (state_nxt_s == ST_FETCH);
      if (accept_s) begin
        gfx_addr <= {PP18, tile_s.code, PP[2:0]};
        pal_r    <= tile_s.pal;
`ifdef PF_HFLIP_EN
        hflip_r  <= tile_s.hflip;
`else
        hflip_r  <= 1'b0;
`endif
      end
      if (ack_s && !bypass_s) buf_r <= ack_row_s;
      if (line_start)  pix_cnt_r <= 3'd0;
      else if (pix_en) pix_cnt_r <= pix_cnt_r + 3'd1;
      if (reload_s && !drain_s && !bypass_s) underrun_err <= 1'b1;
      if (tile_ld && !accept_s)              overrun_err  <= 1'b1;
    end
  end

  pf_pixel_window u_window (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .line_start (line_start),
    .reload     (reload_s),
    .load_row   (load_row_s),
    .hscroll    (hscroll),
    .pix_cnt    (pix_cnt_r),
    .pf_pix     (pf_pix),
    .pf_pal     (pf_pal),
    .pf_hflip   (pf_hflip)
  );

endmodule

// File: tb/tb_playfield_shifter.sv
// Self-checking bench for playfield_shifter: tile-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_playfield_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b1;
  logic        line_start = 1'b0;
  logic        tile_ld = 1'b0;
  logic [15:0] VRD = 16'd0;
  logic        PP18 = 1'b0;
  logic [8:0]  PP = 9'd0;
  logic [2:0]  hscroll = 3'd0;
  logic        gfx_req;
  logic [15:0] gfx_addr;
  logic        gfx_ack = 1'b0;
  logic [31:0] gfx_data = 32'd0;
  logic [3:0]  pf_pix;
  logic [2:0]  pf_pal;
  logic        pf_hflip;
  logic        underrun_err;
  logic        overrun_err;

  always #5 clk = ~clk;

`ifdef PF_HFLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  playfield_shifter dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .line_start(line_start),
    .tile_ld(tile_ld), .VRD(VRD), .PP18(PP18), .PP(PP), .hscroll(hscroll),
    .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack), .gfx_data(gfx_data),
    .pf_pix(pf_pix), .pf_pal(pf_pal), .pf_hflip(pf_hflip),
    .underrun_err(underrun_err), .overrun_err(overrun_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: tiles as arrays of display-order pixels.
  bit          m_busy, m_have, m_rflip, m_bflip;
  logic [15:0] m_addr;
  int          m_rpal, m_bpal, m_cnt, m_hs;
  int          m_buf[8];
  int          m_win[16];
  int          m_wpal[2];
  bit          m_wflip[2];
  logic [3:0]  e_pix = 4'd0;
  logic [2:0]  e_pal = 3'd0;
  logic        e_flip = 1'b0, e_req = 1'b0, e_under = 1'b0, e_over = 1'b0;
  logic [15:0] e_addr = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel k of a tile row as the screen shows it.
  function automatic int pix_of(logic [31:0] d, bit fl, int k);
    int n;
    n = fl ? 7 - k : k;
    return int'((d >> (28 - 4 * n)) & 32'hF);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_have = 0; m_rflip = 0; m_bflip = 0; m_addr = 16'd0;
    m_rpal = 0; m_bpal = 0; m_cnt = 0; m_hs = 0;
    for (int i = 0; i < 8; i++) m_buf[i] = 0;
    for (int i = 0; i < 16; i++) m_win[i] = 0;
    m_wpal[0] = 0; m_wpal[1] = 0; m_wflip[0] = 0; m_wflip[1] = 0;
    e_pix = 4'd0; e_pal = 3'd0; e_flip = 1'b0; e_req = 1'b0;
    e_under = 1'b0; e_over = 1'b0; e_addr = 16'd0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit ack_v, reload, accept;
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    ack_v  = m_busy && gfx_ack;
    reload = pix_en && !line_start && (m_cnt == 7);
    accept = tile_ld && !m_busy && (!m_have || reload);
    if (pix_en && !line_start) begin
      idx    = 8 + m_cnt - m_hs;
      e_pix  = 4'(m_win[idx]);
      e_pal  = 3'(m_wpal[idx / 8]);
      e_flip = m_wflip[idx / 8];
    end
    if (tile_ld && !accept) e_over = 1'b1;
    if (reload) begin
      for (int i = 0; i < 8; i++) m_win[i] = m_win[i + 8];
      m_wpal[0] = m_wpal[1];
      m_wflip[0] = m_wflip[1];
      if (m_have) begin
        for (int i = 0; i < 8; i++) m_win[8 + i] = m_buf[i];
        m_wpal[1] = m_bpal; m_wflip[1] = m_bflip; m_have = 0;
      end else if (ack_v) begin
        for (int i = 0; i < 8; i++) m_win[8 + i] = pix_of(gfx_data, m_rflip, i);
        m_wpal[1] = m_rpal; m_wflip[1] = m_rflip; m_busy = 0; ack_v = 0;
      end else begin
        for (int i = 0; i < 8; i++) m_win[8 + i] = 0;
        m_wpal[1] = 0; m_wflip[1] = 0; e_under = 1'b1;
      end
      m_hs = int'(hscroll);
    end
    if (ack_v) begin
      for (int i = 0; i < 8; i++) m_buf[i] = pix_of(gfx_data, m_rflip, i);
      m_bpal = m_rpal; m_bflip = m_rflip; m_have = 1; m_busy = 0;
    end
    if (accept) begin
      m_busy  = 1;
      m_addr  = {PP18, VRD[11:0], PP[2:0]};
      m_rpal  = int'(VRD[14:12]);
      m_rflip = FLIP && VRD[15];
    end
    if (line_start) begin
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_win[i] = 0;
      m_wpal[0] = 0; m_wpal[1] = 0; m_wflip[0] = 0; m_wflip[1] = 0;
    end else if (pix_en) begin
      m_cnt = (m_cnt + 1) % 8;
    end
    e_req  = m_busy;
    e_addr = m_addr;
  endtask

  // Every-cycle comparison against the model, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("req", gfx_req, e_req);
      check("addr", gfx_addr, e_addr);
      check("pix", pf_pix, e_pix);
      check("pal", pf_pal, e_pal);
      check("hflip", pf_hflip, e_flip);
      check("underrun", underrun_err, e_under);
      check("overrun", overrun_err, e_over);
    end
  end

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tile_ld = 1'b0; gfx_ack = 1'b0; line_start = 1'b0; pix_en = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Load one tile at E1, ack at E3, reload at E8, then check E9..E16 pixels.
  task automatic tile_show(input logic [15:0] vrd, input logic [31:0] data,
                           input bit flipped, input string tag);
    do_reset();
    hscroll = 3'd0; VRD = vrd; PP = 9'd3; PP18 = 1'b0;
    tile_ld = 1'b1; step(); tile_ld = 1'b0;
    check({tag, "_addr"}, gfx_addr, 32'h091B);
    check({tag, "_req"}, gfx_req, 32'd1);
    step();
    gfx_ack = 1'b1; gfx_data = data; step(); gfx_ack = 1'b0;
    repeat (5) step();
    for (int k = 0; k < 8; k++) begin
      step();
      check({tag, "_pix"}, pf_pix, flipped ? 32'(7 - k) : 32'(k));
      check({tag, "_flip"}, pf_hflip, 32'(flipped));
    end
  endtask

  initial begin
    int exp3[8];
    exp3 = '{1, 1, 1, 2, 2, 2, 2, 2};
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    do_reset();
    check("rst_pix", pf_pix, 32'd0);
    check("rst_req", gfx_req, 32'd0);

    // Plain and flipped tile
    tile_show(16'h0123, 32'h01234567, 1'b0, "t1");
    tile_show(16'h8123, 32'h01234567, FLIP, "t2");

    // Two tiles with fine scroll 3
    do_reset();
    hscroll = 3'd3; PP = 9'd0;
    VRD = 16'h1005; tile_ld = 1'b1; step(); tile_ld = 1'b0;
    gfx_ack = 1'b1; gfx_data = 32'h11111111; step(); gfx_ack = 1'b0;
    repeat (6) step();
    VRD = 16'h2006; tile_ld = 1'b1; step(); tile_ld = 1'b0;
    gfx_ack = 1'b1; gfx_data = 32'h22222222; step(); gfx_ack = 1'b0;
    repeat (6) step();
    for (int k = 0; k < 8; k++) begin
      step();
      check("t3_pix", pf_pix, 32'(exp3[k]));
      check("t3_pal", pf_pal, 32'(exp3[k]));
    end
    hscroll = 3'd0;

    // Underrun: no ack before the reload edge
    do_reset();
    VRD = 16'h0123; PP = 9'd3; tile_ld = 1'b1; step(); tile_ld = 1'b0;
    repeat (7) step();
    check("t4_under", underrun_err, 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t4_pix", pf_pix, 32'd0);
    end
    gfx_ack = 1'b1; step(); gfx_ack = 1'b0;

    // Ack exactly on the reload edge bypasses into the window
    do_reset();
    VRD = 16'h3123; tile_ld = 1'b1; step(); tile_ld = 1'b0;
    repeat (6) step();
    gfx_ack = 1'b1; gfx_data = 32'h89ABCDEF; step(); gfx_ack = 1'b0;
    check("t5_under", underrun_err, 32'd0);
    check("t5_req", gfx_req, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t5_pix", pf_pix, 32'(8 + k));
      check("t5_pal", pf_pal, 32'd3);
    end

    // Overrun: two more tile strobes while fetching
    do_reset();
    VRD = 16'h0123; PP = 9'd3; tile_ld = 1'b1; step();
    VRD = 16'h0456; step();
    VRD = 16'h0789; step(); tile_ld = 1'b0;
    check("t6_over", overrun_err, 32'd1);
    check("t6_addr", gfx_addr, 32'h091B);
    gfx_ack = 1'b1; gfx_data = 32'h76543210; step(); gfx_ack = 1'b0;
    repeat (10) step();

    // Reset in the middle of a fetch, then a late ack
    do_reset();
    VRD = 16'h0123; tile_ld = 1'b1; step(); tile_ld = 1'b0;
    check("t7_req_on", gfx_req, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("t7_req_off", gfx_req, 32'd0);
    gfx_ack = 1'b1; gfx_data = 32'hFFFFFFFF; step(); gfx_ack = 1'b0;
    check("t7_req_idle", gfx_req, 32'd0);
    check("t7_pix", pf_pix, 32'd0);
    check("t7_addr", gfx_addr, 32'd0);
    repeat (3) step();
    check("t7_req_stay", gfx_req, 32'd0);

    // Pixel-enable gaps, line_start and a bank-1 address
    do_reset();
    hscroll = 3'd2; VRD = 16'h5ABC; PP = 9'h1F5; PP18 = 1'b1;
    tile_ld = 1'b1; step(); tile_ld = 1'b0;
    check("t8_addr", gfx_addr, 32'hD5E5);
    gfx_ack = 1'b1; gfx_data = 32'hFEDCBA98; step(); gfx_ack = 1'b0;
    for (int i = 0; i < 48; i++) begin
      pix_en     = (i % 3) != 2;
      line_start = (i == 30);
      tile_ld    = (i == 12);
      VRD        = 16'hC321;
      gfx_ack    = (i == 15);
      gfx_data   = 32'h13579BDF;
      step();
    end
    pix_en = 1'b1; line_start = 1'b0; tile_ld = 1'b0; gfx_ack = 1'b0;
    repeat (4) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
